// File: rtl/xor_rot_cipher_pkg.sv
// ---------------------------------------------------------------------------
// xor_rot_cipher_pkg
//   Shared definitions for the iterative XOR-and-rotate cipher core:
//   - state_e  : controller states (IDLE, EXPAND, READY, RUN, DONE)
//   - MODE_ENC / MODE_DEC : values of the per-block mode bit
//   - rotl / rotr : width-parameterised rotate helpers
// The rotate helpers work on a MAX_W-bit container. The caller passes the
// real block width, zero-extends its operand into the container, and
// truncates the result back to the block width.
// ---------------------------------------------------------------------------
package xor_rot_cipher_pkg;

  localparam int MAX_W = 64;

  localparam logic MODE_ENC = 1'b1;
  localparam logic MODE_DEC = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXPAND = 3'd1,
    ST_READY  = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  // Rotate the low w bits of x left by amt (modulo w). Bits at w and above
  // are returned as zero.
  function automatic logic [MAX_W-1:0] rotl(input logic [MAX_W-1:0] x,
                                            input int unsigned       amt,
                                            input int unsigned       w);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (i < w) begin
        r[(i + amt) % w] = x[i];
      end
    end
    return r;
  endfunction

  // Rotate right is a left rotate by the complementary amount.
  function automatic logic [MAX_W-1:0] rotr(input logic [MAX_W-1:0] x,
                                            input int unsigned       amt,
                                            input int unsigned       w);
    return rotl(x, (w - (amt % w)) % w, w);
  endfunction

endpackage

// File: rtl/xor_rot_key_sched.sv
// ---------------------------------------------------------------------------
// xor_rot_key_sched
//   Round-key buffer and expansion engine.
//   rk[0] = key, rk[i] = rotl(rk[i-1], 1) ^ i  (i zero-extended to WIDTH).
//   One entry is written per cycle while `expand` is high; `exp_last` flags
//   the cycle that writes rk[ROUNDS-1].
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   load       : capture key_in and restart the expansion counter
//   key_in     : cipher key
//   expand     : controller is in EXPAND; write one entry this cycle
//   exp_last   : this cycle writes the final entry
//   rd_idx     : round index for the read port
//   rd_key     : rk[rd_idx]
// ---------------------------------------------------------------------------
module xor_rot_key_sched
  import xor_rot_cipher_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4,
  parameter int CNT_W  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] key_in,
  input  logic             expand,
  output logic             exp_last,
  input  logic [CNT_W-1:0] rd_idx,
  output logic [WIDTH-1:0] rd_key
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  // cur holds the entry to be written this cycle; it is advanced in step
  // with the counter so the buffer is never read during expansion.
  logic [WIDTH-1:0] cur_q, cur_d;
  logic [WIDTH-1:0] rk_q [ROUNDS];
  logic [WIDTH-1:0] rk_d [ROUNDS];

  assign exp_last = (cnt_q == CNT_W'(ROUNDS - 1));
  assign rd_key   = rk_q[rd_idx];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    cnt_d = cnt_q;
    cur_d = cur_q;
    rk_d  = rk_q;
    if (load) begin
      cnt_d = '0;
      cur_d = key_in;
    end else if (expand) begin
      rk_d[cnt_q] = cur_q;
      cur_d = WIDTH'(rotl(MAX_W'(cur_q), 1, WIDTH)) ^ (WIDTH'(cnt_q) + WIDTH'(1));
      cnt_d = exp_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: the round-key buffer sits in flops and is cleared by reset, so a
  // reset really does wipe the key material rather than leaving it behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      cur_q <= '0;
      for (int i = 0; i < ROUNDS; i++) begin
        rk_q[i] <= '0;
      end
    end else begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples the pre-edge values, regardless of statement order.
      cnt_q <= cnt_d;
      cur_q <= cur_d;
      rk_q  <= rk_d;
    end
  end

endmodule

// File: rtl/xor_rot_cipher.sv
// ---------------------------------------------------------------------------
// xor_rot_cipher
//   Iterative XOR-and-rotate block cipher, one round per clock.
//   Encrypt round r (0..ROUNDS-1):      x = rotl(x ^ rk[r], ROT)
//   Decrypt round r (ROUNDS-1 down to 0): x = rotr(x, ROT) ^ rk[r]
//   Key expansion is done once per key_load and buffered in
//   xor_rot_key_sched.
// Parameters: WIDTH (>=4, <=64), ROUNDS (1..16), ROT (0 < ROT < WIDTH)
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   key_load, key_in    : load a key and start expansion
//   key_ready           : key_load is honoured (IDLE or READY)
//   in_valid/in_ready   : input handshake; in_mode (1=enc) and in_data
//   out_valid/out_ready : output handshake; out_data holds while valid
//   busy                : EXPAND, RUN or DONE
// Optional feature macro XOR_ROT_CIPHER_PARITY_EN adds out_parity, the
// even parity (XOR reduction) of out_data, registered alongside it.
// ---------------------------------------------------------------------------
module xor_rot_cipher
  import xor_rot_cipher_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ROUNDS = 4,
  parameter int ROT    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [WIDTH-1:0] key_in,
  output logic             key_ready,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_mode,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
`ifdef XOR_ROT_CIPHER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int RND_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
  localparam logic [RND_W-1:0] RND_LAST = RND_W'(ROUNDS - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             mode_q, mode_d;
  logic [RND_W-1:0] rnd_q, rnd_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
`ifdef XOR_ROT_CIPHER_PARITY_EN
  logic             out_parity_q, out_parity_d;
`endif

  logic             key_accept;
  logic             exp_last;
  logic [WIDTH-1:0] round_key;
  logic [WIDTH-1:0] round_out;
  logic             round_last;

  xor_rot_key_sched #(
    .WIDTH  (WIDTH),
    .ROUNDS (ROUNDS),
    .CNT_W  (RND_W)
  ) u_key_sched (
    .clk      (clk),
    .rst      (rst),
    .load     (key_accept),
    .key_in   (key_in),
    .expand   (state_q == ST_EXPAND),
    .exp_last (exp_last),
    .rd_idx   (rnd_q),
    .rd_key   (round_key)
  );

  // Handshake outputs decode the state register only; in_ready also looks
  // at key_load so a key reload wins over a block in the same cycle.
  assign key_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
  assign in_ready  = (state_q == ST_READY) && !key_load;
  assign out_valid = (state_q == ST_DONE);
  assign busy      = (state_q == ST_EXPAND) || (state_q == ST_RUN) ||
                     (state_q == ST_DONE);
  assign out_data  = out_data_q;
`ifdef XOR_ROT_CIPHER_PARITY_EN
  assign out_parity = out_parity_q;
`endif

  // One round of the datapath for the current round key.
  always_comb begin
    if (mode_q == MODE_ENC) begin
      round_out  = WIDTH'(rotl(MAX_W'(data_q ^ round_key), ROT, WIDTH));
      round_last = (rnd_q == RND_LAST);
    end else begin
      round_out  = WIDTH'(rotr(MAX_W'(data_q), ROT, WIDTH)) ^ round_key;
      round_last = (rnd_q == '0);
    end
  end

  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    mode_d     = mode_q;
    rnd_d      = rnd_q;
    out_data_d = out_data_q;
`ifdef XOR_ROT_CIPHER_PARITY_EN
    out_parity_d = out_parity_q;
`endif
    key_accept = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (key_load) begin
          key_accept = 1'b1;
          state_d    = ST_EXPAND;
        end
      end

      ST_EXPAND: begin
        if (exp_last) begin
          state_d = ST_READY;
        end
      end

      ST_READY: begin
        if (key_load) begin
          key_accept = 1'b1;
          state_d    = ST_EXPAND;
        end else if (in_valid) begin
          data_d  = in_data;
          mode_d  = in_mode;
          // Encrypt walks the key buffer upwards, decrypt downwards.
          rnd_d   = (in_mode == MODE_ENC) ? '0 : RND_LAST;
          state_d = ST_RUN;
        end
      end

      ST_RUN: begin
        data_d = round_out;
        if (round_last) begin
          out_data_d = round_out;
`ifdef XOR_ROT_CIPHER_PARITY_EN
          out_parity_d = ^round_out;
`endif
          state_d = ST_DONE;
        end else if (mode_q == MODE_ENC) begin
          rnd_d = rnd_q + RND_W'(1);
        end else begin
          rnd_d = rnd_q - RND_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_READY;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      mode_q     <= MODE_DEC;
      rnd_q      <= '0;
      out_data_q <= '0;
`ifdef XOR_ROT_CIPHER_PARITY_EN
      out_parity_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      data_q     <= data_d;
      mode_q     <= mode_d;
      rnd_q      <= rnd_d;
      out_data_q <= out_data_d;
`ifdef XOR_ROT_CIPHER_PARITY_EN
      out_parity_q <= out_parity_d;
`endif
    end
  end

endmodule

// File: tb/tb_xor_rot_cipher.sv
// ---------------------------------------------------------------------------
// tb_xor_rot_cipher
//   Directed bench for xor_rot_cipher. u_dut uses the default parameters
//   (WIDTH=8, ROUNDS=4, ROT=3); u_dut_r1 uses ROUNDS=1.
//   Key 0x3C expands to rk = {3C, 79, F0, E2}.
//   Encrypt A5 -> 40, encrypt 7E -> FD (4 rounds); encrypt A5 -> CC (1 round).
// ---------------------------------------------------------------------------
module tb_xor_rot_cipher;

  logic       clk = 1'b0;
  logic       rst;

  // default-parameter instance
  logic       key_load, key_ready, in_valid, in_ready, in_mode;
  logic       out_valid, out_ready, busy;
  logic [7:0] key_in, in_data, out_data;
`ifdef XOR_ROT_CIPHER_PARITY_EN
  logic       out_parity;
`endif

  // ROUNDS=1 instance
  logic       r1_key_load, r1_key_ready, r1_in_valid, r1_in_ready, r1_in_mode;
  logic       r1_out_valid, r1_out_ready, r1_busy;
  logic [7:0] r1_key_in, r1_in_data, r1_out_data;
`ifdef XOR_ROT_CIPHER_PARITY_EN
  logic       r1_out_parity;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xor_rot_cipher u_dut (
    .clk       (clk),
    .rst       (rst),
    .key_load  (key_load),
    .key_in    (key_in),
    .key_ready (key_ready),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
`ifdef XOR_ROT_CIPHER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  xor_rot_cipher #(.WIDTH(8), .ROUNDS(1), .ROT(3)) u_dut_r1 (
    .clk       (clk),
    .rst       (rst),
    .key_load  (r1_key_load),
    .key_in    (r1_key_in),
    .key_ready (r1_key_ready),
    .in_valid  (r1_in_valid),
    .in_ready  (r1_in_ready),
    .in_mode   (r1_in_mode),
    .in_data   (r1_in_data),
    .out_valid (r1_out_valid),
    .out_ready (r1_out_ready),
    .out_data  (r1_out_data),
    .busy      (r1_busy)
`ifdef XOR_ROT_CIPHER_PARITY_EN
    ,
    .out_parity(r1_out_parity)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [7:0] k);
    int n;
    check("load_key_ready", key_ready, 1);
    key_load = 1'b1;
    key_in   = k;
    step();
    key_load = 1'b0;
    check("expand_busy", busy, 1);
    check("expand_key_ready", key_ready, 0);
    n = 0;
    while (!key_ready && n < 40) begin
      step();
      n++;
    end
    check("expand_cycles", n, 4);
  endtask

  // Apply one block with out_ready already high; check latency and result,
  // then the DONE->READY return.
  task automatic run_block(input string tag, input logic mode,
                           input logic [7:0] din, input logic [7:0] exp);
    int n;
    check({tag, "_in_ready"}, in_ready, 1);
    in_valid = 1'b1;
    in_mode  = mode;
    in_data  = din;
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 40) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 4);
    check({tag, "_data"}, out_data, exp);
    step();
    check({tag, "_back_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [7:0] held;
    rst = 1'b1;
    key_load = 0; key_in = 0; in_valid = 0; in_mode = 0; in_data = 0; out_ready = 1;
    r1_key_load = 0; r1_key_in = 0; r1_in_valid = 0; r1_in_mode = 0; r1_in_data = 0;
    r1_out_ready = 1;
    #1;
    check("rst_key_ready", key_ready, 1);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
`ifdef XOR_ROT_CIPHER_PARITY_EN
    check("rst_parity", out_parity, 0);
`endif
    step();
    step();
    rst = 1'b0;
    step();

    // ---------------- ROUNDS=1 instance ----------------
    r1_key_load = 1'b1;
    r1_key_in   = 8'h3C;
    step();
    r1_key_load = 1'b0;
    check("r1_expand_busy", r1_busy, 1);
    step();
    check("r1_ready", r1_in_ready, 1);
    r1_in_valid = 1'b1;
    r1_in_mode  = 1'b1;
    r1_in_data  = 8'hA5;
    step();
    r1_in_valid = 1'b0;
    check("r1_enc_not_yet", r1_out_valid, 0);
    step();
    check("r1_enc_valid", r1_out_valid, 1);
    check("r1_enc_data", r1_out_data, 8'hCC);
`ifdef XOR_ROT_CIPHER_PARITY_EN
    check("r1_enc_parity", r1_out_parity, 0);
`endif
    step();
    check("r1_back_ready", r1_in_ready, 1);
    r1_in_valid = 1'b1;
    r1_in_mode  = 1'b0;
    r1_in_data  = 8'hCC;
    step();
    r1_in_valid = 1'b0;
    step();
    check("r1_dec_valid", r1_out_valid, 1);
    check("r1_dec_data", r1_out_data, 8'hA5);
    step();

    // ---------------- default instance ----------------
    check("idle_in_ready", in_ready, 0);
    load_key(8'h3C);
    check("rk0", u_dut.u_key_sched.rk_q[0], 8'h3C);
    check("rk1", u_dut.u_key_sched.rk_q[1], 8'h79);
    check("rk2", u_dut.u_key_sched.rk_q[2], 8'hF0);
    check("rk3", u_dut.u_key_sched.rk_q[3], 8'hE2);

    run_block("enc_a5", 1'b1, 8'hA5, 8'h40);
    run_block("dec_40", 1'b0, 8'h40, 8'hA5);
    run_block("enc_7e", 1'b1, 8'h7E, 8'hFD);
    run_block("dec_fd", 1'b0, 8'hFD, 8'h7E);

    // Output backpressure: result must hold for 5 stalled cycles.
    out_ready = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) step();
    check("bp_valid", out_valid, 1);
    held = out_data;
    check("bp_data", held, 8'h40);
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data", out_data, 8'h40);
      check("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);

    // key_load and in_valid together in READY: reload wins, block dropped.
    key_load = 1'b1; key_in = 8'h3C;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h11;
    #1;
    check("both_in_ready", in_ready, 0);
    step();
    key_load = 1'b0;
    in_valid = 1'b0;
    check("both_expand_busy", busy, 1);
    check("both_expand_key_ready", key_ready, 0);
    for (int i = 0; i < 40 && !key_ready; i++) step();
    check("both_ready_again", in_ready, 1);
    check("both_no_result", out_valid, 0);

    // key_load during RUN is ignored.
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'h7E;
    step();
    in_valid = 1'b0;
    step();
    check("run_key_ready", key_ready, 0);
    key_load = 1'b1; key_in = 8'h00;
    step();
    key_load = 1'b0;
    for (int i = 0; i < 40 && !out_valid; i++) step();
    check("run_kl_data", out_data, 8'hFD);
    step();
    run_block("post_kl_dec", 1'b0, 8'hFD, 8'h7E);

    // Reset in the middle of round 2.
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'hA5;
    step();
    in_valid = 1'b0;
    step();
    step();
    check("mid_run_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mrst_out_valid", out_valid, 0);
    check("mrst_out_data", out_data, 0);
    check("mrst_busy", busy, 0);
    check("mrst_key_ready", key_ready, 1);
    check("mrst_in_ready", in_ready, 0);
    check("mrst_rk1_cleared", u_dut.u_key_sched.rk_q[1], 0);
    step();
    rst = 1'b0;
    in_valid = 1'b1; in_mode = 1'b1; in_data = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nokey_in_ready", in_ready, 0);
      check("nokey_busy", busy, 0);
    end
    in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_rot_cipher.md
# xor_rot_cipher

Iterative, parametrised block cipher core that generalises the team's 8-bit combinational encrypt/decrypt datapath. It runs a configurable number of XOR-and-rotate rounds, one round per clock, over a WIDTH-bit block, with a key schedule that is expanded once and buffered. Blocks enter and leave over valid/ready handshakes. The core sits between the input capture logic and the output register stage of the cryptosystem top level.

## Interface
- WIDTH, 8: block and key width in bits; WIDTH >= 4.
- ROUNDS, 4: number of rounds; 1..16.
- ROT, 3: per-round rotate amount; 0 < ROT < WIDTH.

- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- key_load  in  1  load key_in and start key expansion.
- key_in  in  WIDTH  cipher key.
- key_ready  out  1  high in IDLE and READY; key_load is honoured only when high.
- in_valid  in  1  input block valid.
- in_ready  out  1  high only in READY and when key_load = 0.
- in_mode  in  1  1 = encrypt, 0 = decrypt; sampled with the block.
- in_data  in  WIDTH  input block.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  WIDTH  result; holds its value while out_valid = 1.
- busy  out  1  high in EXPAND, RUN and DONE.

## Operation
- Key schedule: rk[0] = key; rk[i] = rotl(rk[i-1], 1) ^ i, for i = 1..ROUNDS-1. The index i is zero-extended to WIDTH bits.
- Encrypt round r, for r = 0..ROUNDS-1: x = rotl(x ^ rk[r], ROT).
- Decrypt round r, for r = ROUNDS-1 down to 0: x = rotr(x, ROT) ^ rk[r].
- States:
  - IDLE: no key. in_ready = 0. key_load moves to EXPAND.
  - EXPAND: writes rk[0..ROUNDS-1], one entry per cycle, then moves to READY.
  - READY: an in_valid && in_ready handshake latches data and mode, and moves to RUN. key_load moves to EXPAND and takes priority over in_valid in the same cycle.
  - RUN: one round per cycle. The round counter counts up for encrypt and down for decrypt. After the last round, moves to DONE.
  - DONE: out_valid = 1. out_valid && out_ready moves to READY.
- key_load is ignored in EXPAND, RUN and DONE.
- in_valid is ignored outside READY; the block is not consumed.
- All rotates are modulo WIDTH. All arithmetic is truncated to WIDTH bits.

## Timing
- Reset values (asynchronous): state = IDLE, key_ready = 1, in_ready = 0, out_valid = 0, out_data = 0, busy = 0. The round-key buffer is cleared to 0.
- Reset asserted mid-expansion or mid-run aborts immediately. A fresh key_load is required afterwards.
- Key expansion: the key_load edge enters EXPAND. READY is entered ROUNDS cycles later.
- Block latency: the accept edge is E0. out_valid rises after edge E0+ROUNDS.
- Back-to-back: with out_ready held at 1, the DONE-to-READY transition takes one cycle, so the minimum spacing is ROUNDS+2 cycles per block.
- Output backpressure: out_valid and out_data hold stable until out_ready.
- in_ready is combinational from the state register and key_load. It has no combinational path from in_valid.

## Configuration
- XOR_ROT_CIPHER_PARITY_EN defined:
  - Adds output port out_parity (1 bit) = ^out_data, registered with out_data.
  - Resets to 0.
  - Valid only while out_valid = 1.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package xor_rot_cipher_pkg holds:
  - the state enum (IDLE, EXPAND, READY, RUN, DONE);
  - MODE_ENC = 1'b1 and MODE_DEC = 1'b0;
  - parameterised rotl and rotr functions.
- Sub-module xor_rot_key_sched owns:
  - the ROUNDS x WIDTH round-key buffer;
  - the expansion counter;
  - the read port indexed by the round counter.
- The top module keeps the FSM, data register and handshakes.

## Test plan
- ROUNDS=1, ROT=3, key 0x3C. Encrypt 0xA5 -> out_data 0xCC, out_valid at E0+1. Decrypt 0xCC -> 0xA5.
- Defaults, key 0x3C. After EXPAND, rk[1] = 0x79. Encrypt 0xA5, then decrypt the result -> 0xA5. Same round trip for 0x7E. out_valid at E0+4 each time.
- out_ready held low for 5 cycles after out_valid -> out_data stable, in_ready = 0 throughout. Release -> READY on the next cycle.
- key_load and in_valid both asserted in READY -> in_ready = 0, EXPAND entered, block not accepted. key_load during RUN -> ignored, result unchanged.
- rst asserted during RUN round 2 -> all outputs at reset values. in_valid after reset with no key_load -> in_ready stays 0.
- XOR_ROT_CIPHER_PARITY_EN defined, ROUNDS=1 -> out_data 0xCC gives out_parity = 0.
